shift_exec_stage: RTL

// Execute-stage wrapper around the 16-bit SLL/SRA/ROR shifter. It registers one shift request
// (operand, amount, mode, destination register) and drives the shifter combinationally.
// It then captures the result, its zero flag and the destination tag in an output register.

---
 rtl/shift_exec_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/shift_exec_stage.sv
// -----------------------------------------------------------------------------
// shift_exec_stage
// Execute-stage wrapper around a 16-bit SLL/SRA/ROR shifter. Stage 1 registers
// the request (operand, amount, mode, destination tag). The shifter runs
// combinationally off stage 1. Stage 2 registers the result, its zero flag,
// the illegal-mode error and the tag. Both sides use valid/ready handshakes,
// and flush squashes both stages.
//
// Optional feature macro: SHIFT_EXEC_FLAG_EN
//   When defined, flag_z is an architectural Z flag. It loads out_zero on every
//   output handshake and is not affected by flush. When undefined, flag_z is
//   tied to 0.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous squash of both stages (beats every load)
//   in_valid/ready  request handshake (in_ready is combinational)
//   in_data         value to shift
//   in_shamt        shift amount 0..15
//   in_mode         00 SLL, 01 SRA, 10 ROR, 11 illegal
//   in_tag          destination register
//   out_valid/ready result handshake
//   out_data        shifted result
//   out_tag         destination register of out_data
//   out_zero        out_data == 0
//   out_err         the request had the illegal mode
//   flag_z          architectural Z flag (see macro above)
// -----------------------------------------------------------------------------
module shift_exec_stage #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned SHAMT_W = 4,
    parameter int unsigned TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_zero,
    output logic               out_err,
    output logic               flag_z
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;

    // Operand width expressed in the widened shift-amount width, used for ROR.
    localparam logic [SHAMT_W:0] DATA_W_AMT = (SHAMT_W+1)'(DATA_W);

    // Stage 1 request register
    logic               s1_valid;
    logic [DATA_W-1:0]  s1_data;
    logic [SHAMT_W-1:0] s1_shamt;
    logic [1:0]         s1_mode;
    logic [TAG_W-1:0]   s1_tag;

    // Handshake / advance controls
    logic s1_load;
    logic s2_load;

    // Shifter outputs
    logic [DATA_W-1:0]  sh_result;
    logic               sh_err;
    logic [SHAMT_W:0]   ror_left_amt;

    // Stage 2 advances when it is empty or its current result is being taken.
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign s1_load  = in_valid && in_ready;

    // Complementary left amount for the rotate; an amount of 0 gives a left
    // shift by DATA_W, which yields zero and leaves the operand unchanged.
    assign ror_left_amt = DATA_W_AMT - {1'b0, s1_shamt};

    // Combinational shifter. The illegal mode drives a defined zero so no
    // unknown value can ever be captured into stage 2.
    always_comb begin
        sh_result = '0;
        sh_err    = 1'b0;
        case (s1_mode)
            MODE_SLL: sh_result = s1_data << s1_shamt;
            MODE_SRA: sh_result = $unsigned($signed(s1_data) >>> s1_shamt);
            MODE_ROR: sh_result = (s1_data >> s1_shamt) | (s1_data << ror_left_amt);
            default: begin
                sh_result = '0;
                sh_err    = 1'b1;
            end
        endcase
    end

    // Stage 1: operand register; holds while not advancing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_shamt <= '0;
            s1_mode  <= '0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_shamt <= in_shamt;
            s1_mode  <= in_mode;
            s1_tag   <= in_tag;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: result register; holds out_* stable under backpressure and
    // takes a new result in the same cycle the old one is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_zero  <= 1'b0;
            out_err   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_data  <= sh_result;
            out_tag   <= s1_tag;
            out_zero  <= (sh_result == '0);
            out_err   <= sh_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SHIFT_EXEC_FLAG_EN
    // Architectural Z flag: updates only when a result is actually consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
        end else if (out_valid && out_ready) begin
            flag_z <= out_zero;
        end
    end
`else
    assign flag_z = 1'b0;
`endif

endmodule
